// File: rtl/fir_stream_param.sv
// rtl/fir_stream_param.sv - parametrised streaming direct-form FIR with loadable coefficients and zero-fed drain
module fir_stream_param #(
  parameter int DW   = 4,
  parameter int CW   = 4,
  parameter int TAPS = 8,
  parameter int CNTW = 9,
  localparam int OW  = DW + CW + $clog2(TAPS),
  localparam int AW  = $clog2(TAPS)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_halt,
  input  logic            i_in_valid,
  input  logic [DW-1:0]   i_in,
  input  logic            i_coef_we,
  input  logic [AW-1:0]   i_coef_addr,
  input  logic [CW-1:0]   i_coef_data,
  output logic [OW-1:0]   o_out,
  output logic            o_out_valid,
  output logic            o_done,
  output logic [CNTW-1:0] o_sample_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;

  logic [DW-1:0]   r_x [TAPS];
  logic [CW-1:0]   r_c [TAPS];
  logic [DW-1:0]   w_win [TAPS];
  logic [AW-1:0]   r_drain_cnt;
  logic [OW-1:0]   r_out;
  logic            r_out_valid;
  logic            r_done;
  logic [CNTW-1:0] r_cnt;

  logic            w_shift;
  logic [DW-1:0]   w_shift_data;
  logic            w_start_run;
  logic            w_coef_wr;
  logic            w_drain_last;
  logic [OW-1:0]   w_sum;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-cycle datapath controls
  always_comb begin
    w_next_state = r_state;
    w_shift      = 1'b0;
    w_shift_data = '0;
    w_start_run  = 1'b0;
    w_coef_wr    = 1'b0;
    w_drain_last = (r_drain_cnt == AW'(TAPS - 2));
    case (r_state)
      S_IDLE: begin
        w_coef_wr = i_coef_we;
        if (i_start) begin
          w_start_run  = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (i_in_valid) begin
          w_shift      = 1'b1;
          w_shift_data = i_in;
        end
        if (i_halt) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_shift = 1'b1;
        if (w_drain_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Window as it will look after this cycle's shift; only used when shifting
  assign w_win[0] = w_shift_data;
  for (genvar k = 1; k < TAPS; k++) begin : g_win
    assign w_win[k] = r_x[k-1];
  end

  // Exact multiply-accumulate over the post-shift window
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_sum = w_sum + OW'(w_win[k]) * OW'(r_c[k]);
    end
  end

  // Delay line: cleared at run start, shifted on accepted or drain samples
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_run) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= '0;
      end
    end else if (w_shift) begin
      for (int k = 0; k < TAPS; k++) begin
        r_x[k] <= w_win[k];
      end
    end
  end

  // Coefficient bank: writable only in IDLE, persists across runs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_c[k] <= CW'(1);
      end
    end else if (w_coef_wr && (int'(i_coef_addr) < TAPS)) begin
      r_c[i_coef_addr] <= i_coef_data;
    end
  end

  // Drain length counter, restarts whenever not draining
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != S_DRAIN)) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + AW'(1);
    end
  end

  // Output register: new result on every shift, held otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_shift;
      if (w_shift) begin
        r_out <= w_sum;
      end
    end
  end

  // Saturating output-sample counter, cleared at run start
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_run) begin
      r_cnt <= '0;
    end else if (w_shift && (r_cnt != {CNTW{1'b1}})) begin
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  // Done pulse follows the DONE state by one register stage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
    end
  end

  assign o_out        = r_out;
  assign o_out_valid  = r_out_valid;
  assign o_done       = r_done;
  assign o_sample_cnt = r_cnt;

endmodule

// File: tb/tb_fir_stream_param.sv
// tb/tb_fir_stream_param.sv - self-checking bench for fir_stream_param
module tb_fir_stream_param;

  localparam int DW      = 4;
  localparam int CW      = 4;
  localparam int TAPS    = 8;
  localparam int CNTW    = 9;
  localparam int OW      = DW + CW + $clog2(TAPS);
  localparam int AW      = $clog2(TAPS);
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            halt = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   din = '0;
  logic            coef_we = 1'b0;
  logic [AW-1:0]   coef_addr = '0;
  logic [CW-1:0]   coef_data = '0;
  logic [OW-1:0]   dout;
  logic            out_valid;
  logic            done;
  logic [CNTW-1:0] sample_cnt;

  fir_stream_param #(.DW(DW), .CW(CW), .TAPS(TAPS), .CNTW(CNTW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_halt(halt),
    .i_in_valid(in_valid), .i_in(din), .i_coef_we(coef_we),
    .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .o_out(dout), .o_out_valid(out_valid), .o_done(done),
    .o_sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: history newest-first, coefficients, run phase
  int m_x [TAPS];
  int m_c [TAPS];
  int m_phase;   // 0 idle, 1 run, 2 drain, 3 done
  int m_left;
  int m_out;
  int m_valid;
  int m_done;
  int m_cnt;

  typedef struct {
    int st; int hl; int iv; int d; int we; int a; int cd;
    int ev; int eo; int ed;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_sum();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += m_c[k] * m_x[k];
    return s;
  endfunction

  task automatic m_push(input int v);
    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = v;
  endtask

  task automatic m_reset();
    for (int k = 0; k < TAPS; k++) begin m_x[k] = 0; m_c[k] = 1; end
    m_phase = 0; m_left = 0; m_out = 0; m_valid = 0; m_done = 0; m_cnt = 0;
  endtask

  task automatic m_edge(input int r, input int st, input int hl, input int iv,
                        input int d, input int we, input int a, input int cd);
    int acc = 0;
    if (r != 0) begin
      m_reset();
      return;
    end
    m_done = (m_phase == 3) ? 1 : 0;
    case (m_phase)
      0: begin
        if (we != 0) m_c[a] = cd;
        if (st != 0) begin
          m_phase = 1;
          for (int k = 0; k < TAPS; k++) m_x[k] = 0;
          m_cnt = 0;
        end
      end
      1: begin
        if (iv != 0) begin m_push(d); acc = 1; end
        if (hl != 0) begin m_phase = 2; m_left = TAPS - 1; end
      end
      2: begin
        m_push(0); acc = 1; m_left--;
        if (m_left == 0) m_phase = 3;
      end
      default: m_phase = 0;
    endcase
    m_valid = acc;
    if (acc != 0) begin
      m_out = m_sum();
      if (m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  // One clock: drive, edge, update model, compare all outputs
  task automatic step(input int r, input int st, input int hl, input int iv,
                      input int d, input int we, input int a, input int cd);
    rst = 1'(r); start = 1'(st); halt = 1'(hl); in_valid = 1'(iv);
    din = DW'(d); coef_we = 1'(we); coef_addr = AW'(a); coef_data = CW'(cd);
    @(posedge clk);
    m_edge(r, st, hl, iv, d, we, a, cd);
    #1;
    chk("model_out", int'(dout), m_out);
    chk("model_out_valid", int'(out_valid), m_valid);
    chk("model_done", int'(done), m_done);
    chk("model_sample_cnt", int'(sample_cnt), m_cnt);
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic feed(input int v); step(0, 0, 0, 1, v, 0, 0, 0); endtask

  int drain_exp [7] = '{66, 55, 43, 30, 16, 1, 1};
  int last_out;

  initial begin
    m_reset();

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_out", int'(dout), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(sample_cnt), 0);
    step(0, 0, 1, 1, 3, 0, 0, 0);   // halt in IDLE ignored
    chk("idle_halt_no_out", int'(out_valid), 0);

    // Ramp with unity coefficients
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 50; c++) begin
      feed(c % 16);
      if (c == 0) chk("ramp_out0", int'(dout), 0);
      if (c == 3) chk("ramp_out3", int'(dout), 6);
      if (c == 7) chk("ramp_out7", int'(dout), 28);
      if (c == 49) chk("ramp_out49", int'(dout), 76);
    end
    step(0, 0, 1, 0, 0, 0, 0, 0);
    chk("halt_cycle_no_out", int'(out_valid), 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 1, 1, 9, 1, 2, 5);   // all ignored while draining
      chk("drain_valid", int'(out_valid), 1);
      chk("drain_out", int'(dout), drain_exp[i]);
      chk("drain_no_done", int'(done), 0);
    end
    idle();
    chk("done_pulse", int'(done), 1);
    chk("done_cnt", int'(sample_cnt), 57);
    idle();
    chk("done_one_cycle", int'(done), 0);
    chk("cnt_held", int'(sample_cnt), 57);

    // Coefficient load, run-time write ignored: table of vectors
    for (int k = 0; k < TAPS; k++)
      tbl.push_back('{0, 0, 0, 0, 1, k, (k == 0) ? 3 : ((k == 7) ? 2 : 0), 0, -1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, -1, 0});
    tbl.push_back('{0, 0, 1, 5, 0, 0, 0, 1, 15, 0});
    tbl.push_back('{0, 0, 1, 0, 1, 0, 9, 1, 0, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 1, 10, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0, -1, 0});
    for (int i = 0; i < 7; i++) tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, -1, 1});
    foreach (tbl[i]) begin
      step(0, tbl[i].st, tbl[i].hl, tbl[i].iv, tbl[i].d, tbl[i].we, tbl[i].a, tbl[i].cd);
      chk("tbl_valid", int'(out_valid), tbl[i].ev);
      chk("tbl_done", int'(done), tbl[i].ed);
      if (tbl[i].eo >= 0) chk("tbl_out", int'(dout), tbl[i].eo);
    end

    // Alternating in_valid: output holds, count only valid outputs
    step(0, 1, 0, 0, 0, 0, 0, 0);
    last_out = 0;
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        feed(15);
        chk("alt_valid_pulse", int'(out_valid), 1);
        last_out = int'(dout);
      end else begin
        step(0, 0, 0, 0, $urandom_range(15), 1, 0, 7);
        chk("alt_no_pulse", int'(out_valid), 0);
        chk("alt_out_hold", int'(dout), last_out);
      end
      chk("alt_cnt", int'(sample_cnt), i / 2 + 1);
    end
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) idle();

    // Reset mid-run, coefficients back to 1
    step(0, 1, 0, 0, 0, 0, 0, 0);
    feed(4); feed(6); feed(8);
    step(1, 0, 0, 1, 3, 0, 0, 0);
    chk("midrst_out", int'(dout), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_cnt", int'(sample_cnt), 0);
    chk("midrst_done", int'(done), 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("midrst_no_done", int'(done), 0);
    end
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) feed(1);
    chk("midrst_coef_one", int'(dout), 4);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) idle();

    // start and halt together in IDLE
    step(0, 1, 1, 0, 0, 0, 0, 0);
    feed(7);
    chk("sh_run_entered", int'(out_valid), 1);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < TAPS - 1; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, 0);
      chk("sh_drain_valid", int'(out_valid), 1);
      chk("sh_drain_no_done", int'(done), 0);
    end
    idle();
    chk("sh_done", int'(done), 1);

    // Counter saturation
    step(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < CNT_MAX + 10; i++) feed($urandom_range(15));
    chk("cnt_saturated", int'(sample_cnt), CNT_MAX);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) idle();
    chk("cnt_sat_held", int'(sample_cnt), CNT_MAX);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(199) == 0) ? 1 : 0,
           ($urandom_range(9) == 0) ? 1 : 0,
           ($urandom_range(24) == 0) ? 1 : 0,
           ($urandom_range(9) < 7) ? 1 : 0,
           $urandom_range(15),
           ($urandom_range(3) == 0) ? 1 : 0,
           $urandom_range(TAPS - 1),
           $urandom_range(15));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_stream_param.md
Name: fir_stream_param

Overview:
- Parametrised streaming direct-form FIR filter, the generalised successor to the fixed 4-bit start/halt FIR.
- Adds configurable sample, coefficient and tap widths/counts, run-time loadable coefficients, an input-valid qualifier and a zero-fed drain phase after halt.
- Reports completion with a one-cycle `done` pulse and a running output-sample count.
- Sits between a sample source and downstream logic in the datapath.

Parameters:
- DW, 4: input sample width (unsigned).
- CW, 4: coefficient width (unsigned).
- TAPS, 8: number of taps, >= 2.
- CNTW, 9: width of the output-sample counter.
- OW (localparam): DW+CW+$clog2(TAPS), the output width, chosen so no overflow is possible.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  pulse; begins a run from IDLE.
- halt  in  1  pulse; ends input acceptance during RUN.
- in_valid  in  1  qualifies `in` during RUN.
- in  in  DW  input sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  coefficient index (tap k).
- coef_data  in  CW  coefficient value.
- out  out  OW  filter output, registered.
- out_valid  out  1  `out` holds a new result this cycle.
- done  out  1  one-cycle pulse at end of drain.
- sample_cnt  out  CNTW  outputs produced in the current/last run.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - Forces IDLE.
  - Clears the delay line to 0 and sets every coefficient to 1.
  - Sets out=0, out_valid=0, done=0, sample_cnt=0.
  - Reset mid-run aborts the run with no done pulse.
- States:
  - IDLE: start=1 -> RUN, clear delay line and sample_cnt. halt is ignored.
  - RUN: each edge with in_valid=1 shifts `in` into x[0]. halt=1 -> DRAIN; a sample valid in the same cycle is still accepted.
  - DRAIN: shifts a 0 in every cycle for TAPS-1 cycles, then -> DONE. in, in_valid, start and halt are ignored.
  - DONE: one cycle with done=1, then -> IDLE.
- Arithmetic:
  - y = sum over k=0..TAPS-1 of c[k]*x[k], where x[0] is the newest sample.
  - All terms are unsigned and zero-extended to OW bits; the result is exact, with no truncation or saturation.
- Latency:
  - The sample accepted at edge n (including every zero shifted in during DRAIN) produces out with out_valid=1 in the cycle after edge n, i.e. registered at edge n+1.
  - out_valid=0 in cycles with no accepted sample.
  - out holds its last value when out_valid=0.
- sample_cnt:
  - Increments once per out_valid pulse and saturates at 2^CNTW-1.
  - Held after DONE until the next start or reset.
- Coefficients:
  - coef_we is honoured only in IDLE and writes c[coef_addr] at the edge.
  - Writes in other states are dropped.
  - coef_we together with start in IDLE: the write completes and the run starts; the first sample uses the new value.
  - Coefficients persist across runs and are reset only by rst.
- start outside IDLE is ignored.
- halt while already in DRAIN/DONE, or halt held high for several cycles, has no additional effect.
- in_valid=0 during RUN produces no shift, no output and no count.

Test Plan:
- Default params, coefs=1 after reset. start pulse, then in=cnt[3:0] with in_valid=1 for cnt=0..49:
  - outputs for cnt=0,3,7 are 0, 6, 28.
  - output for cnt=49 is 76 (window 10..15,0,1).
- Continue the previous case with a halt pulse:
  - 7 drain outputs 66, 55, 43, 30, 16, 1, 1 (the window shrinks to the newest surviving samples).
  - Then a done pulse exactly one cycle after the final drain output.
  - sample_cnt=57.
- In IDLE write c[0]=3, c[7]=2, other coefs 0; start; feed 5, then 0s:
  - outputs 15, 0 x6, 10.
  - A coef write issued in RUN is ignored (outputs unchanged).
- In RUN alternate in_valid 1/0 with in=15:
  - out_valid pulses only after valid edges.
  - out holds between pulses.
  - sample_cnt counts only valid outputs.
- Assert rst mid-RUN:
  - next cycle out=0, out_valid=0, sample_cnt=0, no done.
  - coefs return to 1 (next run's 4th output with in=1 is 4).
- start and halt together in IDLE:
  - enters RUN.
  - a later halt enters DRAIN and done follows after TAPS-1 drain outputs.
